// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the fizzbuzz generator/checker pair.
// Token kinds are encoded so that bit1 = divisible by 5 and bit0 = divisible by 3.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    NUM      = 2'd0,
    FIZZ     = 2'd1,
    BUZZ     = 2'd2,
    FIZZBUZZ = 2'd3
  } token_kind_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } chk_state_t;

  localparam int FIZZ_MOD = 3;
  localparam int BUZZ_MOD = 5;

  function automatic token_kind_t kind_from_flags(input logic fizz_hit, input logic buzz_hit);
    return token_kind_t'({buzz_hit, fizz_hit});
  endfunction

endpackage

// File: rtl/fizzbuzz_mod_counter.sv
// Modulo-MOD residue counter. A clear loads the residue of index 1, so the
// counter tracks (idx mod MOD) when idx restarts at 1.
module fizzbuzz_mod_counter #(
  parameter int MOD = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   inc,
  output logic [$clog2(MOD)-1:0] count,
  output logic                   zero
);

  localparam int CW = $clog2(MOD);
  localparam logic [CW-1:0] LAST  = CW'(MOD - 1);
  localparam logic [CW-1:0] FIRST = CW'(1 % MOD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= FIRST;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fizzbuzz_checker.sv
// Consumer of the fizzbuzz token stream: recomputes each expected token and counts mismatches.
// Optional macro FIZZBUZZ_CHECKER_STOP_ON_ERR_EN ends the sequence at the first mismatch.
module fizzbuzz_checker
  import fizzbuzz_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LENGTH    = 100,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [WIDTH-1:0]     in_value,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]     first_err_index
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(LENGTH);

  chk_state_t state_q, state_d;

  logic [WIDTH-1:0]             idx_q;
  logic [ERR_WIDTH-1:0]         err_q;
  logic [WIDTH-1:0]             first_q;
  logic [$clog2(FIZZ_MOD)-1:0]  mod3_count;
  logic [$clog2(BUZZ_MOD)-1:0]  mod5_count;
  logic                         mod3_zero;
  logic                         mod5_zero;
  logic                         start_ok;
  logic                         accept;
  logic                         last_token;
  logic                         mismatch;
  token_kind_t                  exp_kind;

  assign start_ok   = (state_q == IDLE) && start;
  assign accept     = (state_q == RUN) && in_valid;
  assign last_token = (idx_q == LAST_IDX);
  assign exp_kind   = kind_from_flags(mod3_zero, mod5_zero);

  // in_value only matters for numeric tokens; for word tokens the kind alone decides.
  assign mismatch = accept &&
                    ((in_kind != exp_kind) ||
                     ((in_kind == NUM) && (in_value != idx_q)));

  fizzbuzz_mod_counter #(.MOD(FIZZ_MOD)) u_mod3 (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .inc   (accept),
    .count (mod3_count),
    .zero  (mod3_zero)
  );

  fizzbuzz_mod_counter #(.MOD(BUZZ_MOD)) u_mod5 (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .inc   (accept),
    .count (mod5_count),
    .zero  (mod5_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef FIZZBUZZ_CHECKER_STOP_ON_ERR_EN
        if (accept && (mismatch || last_token)) begin
          state_d = FINISH;
        end
`else
        if (accept && last_token) begin
          state_d = FINISH;
        end
`endif
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    pass     = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      FINISH: begin
        done = 1'b1;
        pass = (err_q == '0);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Error statistics survive the return to IDLE and are cleared only by the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else if (start_ok) begin
      idx_q   <= WIDTH'(1);
      err_q   <= '0;
      first_q <= '0;
    end else if (accept) begin
      idx_q <= idx_q + 1'b1;
      if (mismatch) begin
        if (err_q != '1) begin
          err_q <= err_q + 1'b1;
        end
        if (err_q == '0) begin
          first_q <= idx_q;
        end
      end
    end
  end

  assign err_count       = err_q;
  assign first_err_index = first_q;

endmodule

// File: tb/tb_fizzbuzz_checker.sv
// Directed bench for fizzbuzz_checker with LENGTH=15; a second instance with
// ERR_WIDTH=2 shares the stimulus to exercise counter saturation.
module tb_fizzbuzz_checker;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [1:0] in_kind;
  logic [7:0] in_value;

  logic       in_ready, busy, done, pass;
  logic [7:0] err_count, first_err_index;
  logic       sat_in_ready, sat_busy, sat_done, sat_pass;
  logic [1:0] sat_err_count;
  logic [7:0] sat_first_err_index;

  int pass_count  = 0;
  int fail_count  = 0;
  int check_count = 0;
  int done_pulses = 0;
  int pulses_before;

  logic [1:0] kind_tab [1:LENGTH];
  logic [7:0] val_tab  [1:LENGTH];

  fizzbuzz_checker #(.WIDTH(WIDTH), .LENGTH(LENGTH), .ERR_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_value        (in_value),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_index (first_err_index)
  );

  fizzbuzz_checker #(.WIDTH(WIDTH), .LENGTH(LENGTH), .ERR_WIDTH(2)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (sat_in_ready),
    .in_kind         (in_kind),
    .in_value        (in_value),
    .busy            (sat_busy),
    .done            (sat_done),
    .pass            (sat_pass),
    .err_count       (sat_err_count),
    .first_err_index (sat_first_err_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [1:0] model_kind(input int i);
    if (i % 15 == 0) return 2'd3;
    if (i % 5 == 0)  return 2'd2;
    if (i % 3 == 0)  return 2'd1;
    return 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Word tokens carry a junk value on purpose: in_value must be ignored for them.
  task automatic load_clean();
    for (int i = 1; i <= LENGTH; i++) begin
      kind_tab[i] = model_kind(i);
      val_tab[i]  = (model_kind(i) == 2'd0) ? 8'(i) : 8'hEE;
    end
  endtask

  task automatic applyStimulus(input int stall_a, input int stall_b, input int start_mid);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= LENGTH; i++) begin
      if (i == stall_a || i == stall_b) begin
        in_valid = 1'b0;
        in_kind  = 2'd3;
        in_value = 8'h55;
        repeat (3) tick();
        checkOutput("stall_no_done", {31'd0, done}, 32'd0);
      end
      in_valid = 1'b1;
      in_kind  = kind_tab[i];
      in_value = val_tab[i];
      start    = (i == start_mid);
      checkOutput("ready_in_run", {31'd0, in_ready}, 32'd1);
      tick();
      start = 1'b0;
      if (i < LENGTH) checkOutput("no_early_done", {31'd0, done}, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input logic exp_pass, input int exp_err, input int exp_first, input int exp_sat_err);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("finish_busy", {31'd0, busy}, 32'd0);
    checkOutput("finish_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("pass", {31'd0, pass}, {31'd0, exp_pass});
    checkOutput("err_count", {24'd0, err_count}, exp_err);
    checkOutput("first_err_index", {24'd0, first_err_index}, exp_first);
    checkOutput("sat_err_count", {30'd0, sat_err_count}, exp_sat_err);
    checkOutput("sat_first_err_index", {24'd0, sat_first_err_index}, exp_first);
    tick();
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    tick();
    checkOutput("idle_err_hold", {24'd0, err_count}, exp_err);
    checkOutput("idle_first_hold", {24'd0, first_err_index}, exp_first);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_kind  = 2'd0;
    in_value = 8'd0;
    tick();
    tick();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_pass", {31'd0, pass}, 32'd0);
    checkOutput("rst_err", {24'd0, err_count}, 32'd0);
    checkOutput("rst_first", {24'd0, first_err_index}, 32'd0);

    // start held across the deasserting edge must not launch a run
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("start_in_reset_ignored", {31'd0, busy}, 32'd0);

    $display("[TB] clean run");
    load_clean();
    pulses_before = done_pulses;
    applyStimulus(0, 0, 0);
    check_result(1'b1, 0, 0, 0);
    checkOutput("clean_done_count", done_pulses - pulses_before, 32'd1);

`ifndef FIZZBUZZ_CHECKER_STOP_ON_ERR_EN
    $display("[TB] single value error, with start mid-run ignored");
    load_clean();
    val_tab[7] = 8'd8;
    applyStimulus(0, 0, 6);
    check_result(1'b0, 1, 7, 1);

    $display("[TB] kind error with stalls");
    load_clean();
    kind_tab[5] = 2'd1;
    applyStimulus(4, 10, 0);
    check_result(1'b0, 1, 5, 1);

    $display("[TB] every token wrong");
    load_clean();
    for (int i = 1; i <= LENGTH; i++) kind_tab[i] = model_kind(i) ^ 2'd1;
    applyStimulus(0, 0, 0);
    check_result(1'b0, 15, 1, 3);
`else
    $display("[TB] stop on first error");
    load_clean();
    kind_tab[3] = 2'd0;
    val_tab[3]  = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_kind  = kind_tab[i];
      in_value = val_tab[i];
      tick();
    end
    checkOutput("stop_done", {31'd0, done}, 32'd1);
    checkOutput("stop_pass", {31'd0, pass}, 32'd0);
    checkOutput("stop_err", {24'd0, err_count}, 32'd1);
    checkOutput("stop_first", {24'd0, first_err_index}, 32'd3);
    checkOutput("stop_ready", {31'd0, in_ready}, 32'd0);
    in_kind  = kind_tab[4];
    in_value = val_tab[4];
    tick();
    checkOutput("stop_ready_after", {31'd0, in_ready}, 32'd0);
    checkOutput("stop_done_once", {31'd0, done}, 32'd0);
    in_valid = 1'b0;
    tick();
`endif

    $display("[TB] reset mid-sequence");
    load_clean();
    pulses_before = done_pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_kind  = kind_tab[i];
      in_value = 8'hAA;
      tick();
    end
    in_kind  = kind_tab[8];
    in_value = val_tab[8];
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("abort_err", {24'd0, err_count}, 32'd0);
    checkOutput("abort_first", {24'd0, first_err_index}, 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("abort_no_done", done_pulses - pulses_before, 32'd0);
    applyStimulus(0, 0, 0);
    check_result(1'b1, 0, 0, 0);
    checkOutput("rerun_done_count", done_pulses - pulses_before, 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fizzbuzz_checker.md
Name: fizzbuzz_checker

Overview:
- Consumer end of the fizzbuzz token stream. Accepts tokens over a valid/ready handshake and recomputes the expected token for each index 1..LENGTH using internal mod-3/mod-5 counters.
- Flags mismatches and counts errors. Reports pass/fail at end of sequence.
- Sits downstream of the fizzbuzz generator in the sanity design. Also used as a self-checking sink in benches.

Parameters:
- WIDTH, 8, width of index and numeric token value.
- LENGTH, 100, number of tokens in one sequence (1 ≤ LENGTH < 2^WIDTH).
- ERR_WIDTH, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sequence check
- in_valid  input  1  token present
- in_ready  output  1  checker accepts token this cycle
- in_kind  input  2  token kind: 0=NUM, 1=FIZZ, 2=BUZZ, 3=FIZZBUZZ
- in_value  input  WIDTH  numeric value; compared only when kind=NUM
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the last token is accepted
- pass  output  1  valid with done; 1 if err_count==0
- err_count  output  ERR_WIDTH  mismatches this sequence, saturating
- first_err_index  output  WIDTH  index of first mismatch; 0 if none

Behaviour:
- Reset values:
  - in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_index=0.
  - Internal: idx=0, mod3=0, mod5=0, state=IDLE.
- States: IDLE, RUN, FINISH.
- IDLE:
  - in_ready=0.
  - On start: idx←1, mod3←1, mod5←1, err_count←0, first_err_index←0; go to RUN next cycle.
- RUN:
  - in_ready=1, busy=1.
  - A token is accepted when in_valid & in_ready.
  - Expected kind = {mod5==0, mod3==0} (bit1=buzz, bit0=fizz).
  - Mismatch if in_kind≠expected, or if kind=NUM and in_value≠idx.
  - On mismatch:
    - err_count increments, saturating at 2^ERR_WIDTH−1.
    - first_err_index←idx if err_count was 0.
  - After each accept: idx+1; mod3 wraps 2→0, else +1; mod5 wraps 4→0, else +1.
  - Accept at idx==LENGTH: go to FINISH.
  - No accept (in_valid=0): all state holds. No timeout.
- FINISH:
  - Lasts exactly one cycle: done=1, pass=(err_count==0) including the last token's result, busy=0, in_ready=0.
  - Then IDLE.
- Latency: done asserts the cycle after the final accept.
- err_count and first_err_index hold their values in IDLE until the next start.
- start while RUN or FINISH: ignored.
- start in the same cycle as reset deassertion: ignored. Start is sampled only when rst=0 at the edge.
- Reset mid-sequence: immediately returns all outputs to reset values. No done pulse.
- in_value is a don't-care for non-NUM tokens. in_kind and in_value are ignored when not accepted.

Optional Feature:
- Macro: FIZZBUZZ_CHECKER_STOP_ON_ERR_EN.
- Defined:
  - On the first mismatch, go directly to FINISH the next cycle with pass=0 and err_count=1.
  - Remaining tokens are not accepted (in_ready=0).
- Undefined: the full sequence of LENGTH tokens is always consumed, and errors are counted.

Decomposition:
- Shared package fizzbuzz_pkg holds:
  - typedef token kind enum (NUM, FIZZ, BUZZ, FIZZBUZZ) as 2-bit.
  - typedef checker state enum (IDLE, RUN, FINISH).
  - Constants FIZZ_MOD=3 and BUZZ_MOD=5.
- One sub-module: fizzbuzz_mod_counter.
  - Parameter MOD; inputs clk, rst, clear, inc.
  - Outputs count and zero flag.
  - Instantiated twice, for mod3 and mod5.

Test Plan:
- Clean run, LENGTH=15: start, then the correct stream 1,2,FIZZ,4,BUZZ,…,14,FIZZBUZZ with in_valid held high → done at cycle 17 after start, pass=1, err_count=0, first_err_index=0.
- Single error: token 7 sent as NUM value 8 → err_count=1, first_err_index=7, pass=0; all 15 tokens accepted.
- Kind error plus stalls: FIZZ at index 5, with in_valid dropped for 3 cycles at indices 4 and 10 → err_count=1, first_err_index=5, idx holds during stalls, done after 15 accepts.
- Saturation: ERR_WIDTH=2, all 15 tokens wrong → err_count=3, first_err_index=1.
- Reset at index 8, then start and a clean run → no done from the aborted run; second run passes with err_count=0.
- STOP_ON_ERR_EN defined, error at index 3 → done one cycle after that accept, err_count=1, in_ready=0 afterwards.
